// File: rtl/ltpi_gpio_frame_rx.sv
// LTPI GPIO tunnel receiver: delineates 16-byte operational frames from the decoded
// byte stream, checks CRC-8, tracks frame lock and drives the LL/NL GPIO outputs.
module ltpi_gpio_frame_rx #(
   parameter int LL_GPIO_NUM = 16,
   parameter int NL_GPIO_NUM = 128,
   parameter int ALIGN_GOOD  = 3,
   parameter int ALIGN_BAD   = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   input  logic                   rx_k,
   output logic [LL_GPIO_NUM-1:0] ll_gpio_out,
   output logic [NL_GPIO_NUM-1:0] nl_gpio_out,
   output logic                   aligned,
   output logic                   frame_good,
   output logic                   frame_err
);

   localparam int NL_GROUPS = NL_GPIO_NUM / 16;
   localparam int GW = $clog2(ALIGN_GOOD + 1);
   localparam int BW = $clog2(ALIGN_BAD + 1);
   localparam logic [7:0] K28_5 = 8'hBC;

   typedef enum logic {HUNT, COLLECT} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [7:0]               crc_q, crc_d;
   logic [7:0]               sub_q, sub_d;
   logic [7:0]               idx_q, idx_d;
   logic [15:0]              llw_q, llw_d;
   logic [15:0]              nlw_q, nlw_d;
   logic [GW-1:0]            good_cnt_q, good_cnt_d;
   logic [BW-1:0]            bad_cnt_q, bad_cnt_d;
   logic                     aligned_q, aligned_d;
   logic                     good_q, good_d;
   logic                     err_q, err_d;
   logic [LL_GPIO_NUM-1:0]   ll_q, ll_d;
   logic [NL_GPIO_NUM-1:0]   nl_q, nl_d;
   logic                     fin_good, fin_bad;
   logic                     is_comma;

   // CRC-8, poly x^8+x^2+x+1, MSB first, one byte per call
   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] r;
      r = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   assign is_comma = rx_k && (rx_data == K28_5);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      crc_d    = crc_q;
      sub_d    = sub_q;
      idx_d    = idx_q;
      llw_d    = llw_q;
      nlw_d    = nlw_q;
      fin_good = 1'b0;
      fin_bad  = 1'b0;
      if (rx_valid) begin
         case (state_q)
            HUNT: begin
               if (is_comma) begin
                  state_d = COLLECT;
                  cnt_d   = 4'd1;
                  crc_d   = 8'h00;
               end
            end
            COLLECT: begin
               // A comma mid-frame aborts the frame and restarts delineation on itself
               if (is_comma) begin
                  fin_bad = 1'b1;
                  cnt_d   = 4'd1;
                  crc_d   = 8'h00;
               end else if (rx_k) begin
                  fin_bad = 1'b1;
                  state_d = HUNT;
               end else if (cnt_q == 4'd15) begin
                  if (rx_data == crc_q) fin_good = 1'b1;
                  else                  fin_bad  = 1'b1;
                  state_d = HUNT;
               end else begin
                  crc_d = crc8_upd(crc_q, rx_data);
                  cnt_d = cnt_q + 4'd1;
                  case (cnt_q)
                     4'd1:    sub_d        = rx_data;
                     4'd2:    idx_d        = rx_data;
                     4'd3:    llw_d[15:8]  = rx_data;
                     4'd4:    llw_d[7:0]   = rx_data;
                     4'd5:    nlw_d[15:8]  = rx_data;
                     4'd6:    nlw_d[7:0]   = rx_data;
                     default: ;
                  endcase
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      aligned_d  = aligned_q;
      ll_d       = ll_q;
      nl_d       = nl_q;
      good_d     = fin_good;
      err_d      = fin_bad;
      if (fin_good) begin
         bad_cnt_d = '0;
         if (good_cnt_q != GW'(ALIGN_GOOD)) good_cnt_d = good_cnt_q + GW'(1);
         if (good_cnt_d == GW'(ALIGN_GOOD)) aligned_d = 1'b1;
      end
      if (fin_bad) begin
         good_cnt_d = '0;
         if (bad_cnt_q != BW'(ALIGN_BAD)) bad_cnt_d = bad_cnt_q + BW'(1);
         if (bad_cnt_d == BW'(ALIGN_BAD)) aligned_d = 1'b0;
      end
      // GPIO loads only when the frame that completes lock (or later) is a GPIO frame
      if (fin_good && (sub_q == 8'h00) && aligned_d) begin
         ll_d = llw_q[LL_GPIO_NUM-1:0];
         for (int g = 0; g < NL_GROUPS; g++) begin
            if (idx_q == 8'(g)) nl_d[16*g +: 16] = nlw_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HUNT;
         cnt_q      <= '0;
         crc_q      <= 8'h00;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         aligned_q  <= 1'b0;
         good_q     <= 1'b0;
         err_q      <= 1'b0;
         ll_q       <= '0;
         nl_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         aligned_q  <= aligned_d;
         good_q     <= good_d;
         err_q      <= err_d;
         ll_q       <= ll_d;
         nl_q       <= nl_d;
      end
   end

   always_ff @(posedge clk) begin
      sub_q <= sub_d;
      idx_q <= idx_d;
      llw_q <= llw_d;
      nlw_q <= nlw_d;
   end

   assign ll_gpio_out = ll_q;
   assign nl_gpio_out = nl_q;
   assign aligned     = aligned_q;
   assign frame_good  = good_q;
   assign frame_err   = err_q;

endmodule

// File: tb/tb_ltpi_gpio_frame_rx.sv
// Scoreboard bench for ltpi_gpio_frame_rx: a frame-level model queues expected
// pulses and GPIO state; a negedge monitor compares them against the DUT.
module tb_ltpi_gpio_frame_rx;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_k = 1'b0;
   logic [15:0]  ll_gpio_out;
   logic [127:0] nl_gpio_out;
   logic         aligned, frame_good, frame_err;

   ltpi_gpio_frame_rx #(
      .LL_GPIO_NUM(16), .NL_GPIO_NUM(128), .ALIGN_GOOD(3), .ALIGN_BAD(3)
   ) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_k(rx_k),
      .ll_gpio_out(ll_gpio_out), .nl_gpio_out(nl_gpio_out), .aligned(aligned),
      .frame_good(frame_good), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           good;
      logic [15:0]  ll;
      logic [127:0] nl;
      bit           al;
      int           due;
   } exp_t;

   exp_t sb[$];
   exp_t pend[$];
   exp_t mon_e;
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [15:0]  cur_ll = '0;
   logic [127:0] cur_nl = '0;
   bit           cur_al = 1'b0;
   int           m_good = 0, m_bad = 0;
   bit           m_al = 1'b0;
   logic [15:0]  m_ll = '0;
   logic [127:0] m_nl = '0;
   logic [7:0]   fb [16];

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_good || frame_err) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_pulse", 128'({frame_good, frame_err}), 128'(0));
         end else begin
            mon_e = sb.pop_front();
            check_eq("pulse_cycle", 128'(cyc), 128'(mon_e.due));
            check_eq("frame_good", 128'(frame_good), 128'(mon_e.good));
            check_eq("frame_err", 128'(frame_err), 128'(!mon_e.good));
            cur_ll = mon_e.ll; cur_nl = mon_e.nl; cur_al = mon_e.al;
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         check_eq("missing_pulse", 128'({frame_good, frame_err}), mon_e.good ? 128'(2) : 128'(1));
         cur_ll = mon_e.ll; cur_nl = mon_e.nl; cur_al = mon_e.al;
      end
      check_eq("ll_gpio_out", 128'(ll_gpio_out), 128'(cur_ll));
      check_eq("nl_gpio_out", nl_gpio_out, cur_nl);
      check_eq("aligned", 128'(aligned), 128'(cur_al));
   end

   function automatic logic [7:0] crc8_ref(input logic [7:0] b [16]);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 1; i <= 14; i++) begin
         c = c ^ b[i];
         for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   task automatic build(input logic [7:0] sub, input logic [7:0] idx,
                        input logic [15:0] ll, input logic [15:0] nl);
      fb[0] = 8'hBC; fb[1] = sub; fb[2] = idx;
      fb[3] = ll[15:8]; fb[4] = ll[7:0]; fb[5] = nl[15:8]; fb[6] = nl[7:0];
      for (int i = 7; i <= 14; i++) fb[i] = 8'($urandom_range(0, 255));
      fb[15] = crc8_ref(fb);
   endtask

   task automatic model_result(input bit good, input logic [7:0] sub, input logic [7:0] idx,
                               input logic [15:0] ll, input logic [15:0] nl);
      exp_t e;
      if (good) begin
         m_bad = 0;
         if (m_good < 3) m_good++;
         if (m_good == 3) m_al = 1'b1;
         if (sub == 8'h00 && m_al) begin
            m_ll = ll;
            if (idx < 8) m_nl[int'(idx)*16 +: 16] = nl;
         end
      end else begin
         m_good = 0;
         if (m_bad < 3) m_bad++;
         if (m_bad == 3) m_al = 1'b0;
      end
      e.good = good; e.ll = m_ll; e.nl = m_nl; e.al = m_al; e.due = 0;
      pend.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic k, input int stall);
      exp_t e;
      repeat (stall) begin
         rx_valid = 1'b0; rx_data = 8'($urandom_range(0, 255)); rx_k = 1'b1;
         @(posedge clk); #1;
      end
      rx_valid = 1'b1; rx_data = d; rx_k = k;
      while (pend.size() > 0) begin
         e = pend.pop_front();
         e.due = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_k = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] sub, input logic [7:0] idx, input logic [15:0] ll,
                             input logic [15:0] nl, input logic [7:0] crc_x, input int stall);
      build(sub, idx, ll, nl);
      for (int i = 0; i < 15; i++) send_byte(fb[i], (i == 0), stall);
      model_result(crc_x == 8'h00, sub, idx, ll, nl);
      send_byte(fb[15] ^ crc_x, 1'b0, stall);
   endtask

   task automatic send_partial(input int n);
      build(8'h00, 8'h01, 16'hDEAD, 16'hC0DE);
      for (int i = 0; i < n; i++) send_byte(fb[i], (i == 0), 0);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0; rx_k = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      cur_ll = '0; cur_nl = '0; cur_al = 1'b0;
      sb.delete(); pend.delete();
      m_good = 0; m_bad = 0; m_al = 1'b0; m_ll = '0; m_nl = '0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();
      check_eq("rst_ll", 128'(ll_gpio_out), 128'(0));
      check_eq("rst_nl", nl_gpio_out, 128'(0));
      check_eq("rst_aligned", 128'(aligned), 128'(0));
      check_eq("rst_pulses", 128'({frame_good, frame_err}), 128'(0));

      // Idle noise in HUNT must be ignored
      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 0);

      // Lock acquisition
      for (int i = 0; i < 3; i++) begin
         send_frame(8'h00, 8'h00, 16'hA5C3, 16'h1234, 8'h00, 0);
         check_eq("aligned_acquire", 128'(aligned), 128'(i == 2));
      end
      check_eq("ll_after_lock", 128'(ll_gpio_out), 128'(16'hA5C3));
      check_eq("nl0_after_lock", 128'(nl_gpio_out[15:0]), 128'(16'h1234));

      // NL indexing, out-of-range index, non-GPIO subtype
      send_frame(8'h00, 8'h07, 16'h1111, 16'hBEEF, 8'h00, 0);
      send_frame(8'h00, 8'h08, 16'h2222, 16'hFFFF, 8'h00, 0);
      check_eq("nl7", 128'(nl_gpio_out[127:112]), 128'(16'hBEEF));
      check_eq("ll_idx8", 128'(ll_gpio_out), 128'(16'h2222));
      send_frame(8'h01, 8'h03, 16'h3333, 16'h4444, 8'h00, 0);
      check_eq("ll_subtype1", 128'(ll_gpio_out), 128'(16'h2222));

      // Lock loss with held outputs, then relock
      for (int i = 0; i < 3; i++) send_frame(8'h00, 8'h02, 16'h5555, 16'h6666, 8'h01, 0);
      check_eq("aligned_lost", 128'(aligned), 128'(0));
      check_eq("ll_held", 128'(ll_gpio_out), 128'(16'h2222));
      for (int i = 0; i < 3; i++) send_frame(8'h00, 8'h01, 16'h7777, 16'h8888, 8'h00, 0);
      send_frame(8'h00, 8'h01, 16'h7777, 16'h8888, 8'h01, 0);
      send_frame(8'h00, 8'h01, 16'h7777, 16'h8888, 8'h01, 0);
      send_frame(8'h00, 8'h05, 16'h9999, 16'hAAAA, 8'h00, 0);
      check_eq("aligned_2bad_1good", 128'(aligned), 128'(1));

      // Comma abort at byte 9, then K28.7 at byte 5
      send_partial(9);
      model_result(1'b0, 8'h00, 8'h00, 16'h0, 16'h0);
      send_frame(8'h00, 8'h04, 16'hBBBB, 16'hCCCC, 8'h00, 0);
      send_partial(5);
      model_result(1'b0, 8'h00, 8'h00, 16'h0, 16'h0);
      send_byte(8'hFC, 1'b1, 0);
      send_frame(8'h00, 8'h06, 16'hDDDD, 16'hEEEE, 8'h00, 0);
      check_eq("ll_after_recover", 128'(ll_gpio_out), 128'(16'hDDDD));

      // Throttled input, one valid byte in three
      send_frame(8'h00, 8'h03, 16'h0F0F, 16'hF0F0, 8'h00, 2);
      check_eq("nl3_stalled", 128'(nl_gpio_out[63:48]), 128'(16'hF0F0));

      // Reset mid-frame, then relock
      send_partial(10);
      do_reset();
      check_eq("midrst_ll", 128'(ll_gpio_out), 128'(0));
      check_eq("midrst_nl", nl_gpio_out, 128'(0));
      check_eq("midrst_aligned", 128'(aligned), 128'(0));
      for (int i = 0; i < 3; i++) send_frame(8'h00, 8'h02, 16'h1357, 16'h2468, 8'h00, 0);
      check_eq("relock_aligned", 128'(aligned), 128'(1));
      check_eq("relock_nl2", 128'(nl_gpio_out[47:32]), 128'(16'h2468));

      repeat (5) @(posedge clk);
      #1;
      check_eq("sb_drained", 128'(sb.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
